action_dispatch: RTL and testbench

Egress stage placed directly after the stateful match/action stage. Accepts each packet together with its 16-bit action word and 8-bit state, buffers them in a small FIFO, and decodes the forward byte of the action. Each packet is either sent to one egress port, broadcast to every port, sent to the controller port, or dropped. Output uses a valid/ready handshake so downstream MACs can stall without loss; the upstream side has no backpressure, so overflow drops are counted.

---
 rtl/action_dispatch_pkg.sv | 34 +++
 rtl/action_dispatch_if.sv | 27 ++
 rtl/dispatch_fifo.sv | 53 +++++
 rtl/action_dispatch.sv | 195 +++++++++++++++++++
 tb/tb_action_dispatch.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/action_dispatch_pkg.sv
// Shared definitions for the action_dispatch egress stage: action field
// positions, special forward codes, FSM encoding, FIFO metadata payload and
// a saturating counter increment.
package action_dispatch_pkg;

  localparam int unsigned ACTION_W = 16;
  localparam int unsigned STATE_W  = 8;
  localparam int unsigned PORT_W   = 8;
  localparam int unsigned CNT_W    = 32;

  // Forward byte location inside the action word
  localparam int unsigned FWD_HI = 15;
  localparam int unsigned FWD_LO = 8;

  localparam logic [7:0] ACT_BCAST = 8'hFF;
  localparam logic [7:0] ACT_CTRL  = 8'h00;

  typedef enum logic {
    IDLE  = 1'b0,
    BCAST = 1'b1
  } fsm_e;

  // Per-packet metadata stored next to the data word in the FIFO
  typedef struct packed {
    logic [ACTION_W-1:0] action;
    logic [STATE_W-1:0]  state;
  } pkt_meta_t;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/action_dispatch_if.sv
// Packet bus of action_dispatch: upstream packet/action/state inputs (no
// backpressure) and the downstream valid/ready output with port and state.
//   master: upstream + downstream environment (drives inputs and ready)
//   slave : the dispatch stage
interface action_dispatch_if #(
  parameter int unsigned DATA_W = 512
);
  logic              pkt_vld_in;
  logic [DATA_W-1:0] pkt_data_in;
  logic [15:0]       action_in;
  logic [7:0]        state_in;
  logic              pkt_vld_out;
  logic              pkt_rdy_in;
  logic [DATA_W-1:0] pkt_data_out;
  logic [7:0]        pkt_port_out;
  logic [7:0]        pkt_state_out;

  modport master (
    output pkt_vld_in, pkt_data_in, action_in, state_in, pkt_rdy_in,
    input  pkt_vld_out, pkt_data_out, pkt_port_out, pkt_state_out
  );

  modport slave (
    input  pkt_vld_in, pkt_data_in, action_in, state_in, pkt_rdy_in,
    output pkt_vld_out, pkt_data_out, pkt_port_out, pkt_state_out
  );
endinterface

// File: rtl/dispatch_fifo.sv
// First-word-fall-through FIFO with synchronous active-high reset.
//   clk, reset          : clock, sync reset (pointers only)
//   wr_en, wr_data      : write request; ignored while full
//   rd_en               : pop head; ignored while empty
//   rd_data_c           : head entry, valid whenever !empty_c
//   full_c, empty_c     : occupancy flags
module dispatch_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_BITS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data_c,
  output logic             full_c,
  output logic             empty_c
);
  localparam int unsigned DEPTH = 1 << DEPTH_BITS;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_BITS:0] wr_ptr;
  logic [DEPTH_BITS:0] rd_ptr;
  logic                do_wr_c;
  logic                do_rd_c;

  // Extra pointer bit distinguishes full from empty
  assign empty_c = (wr_ptr == rd_ptr);
  assign full_c  = (wr_ptr[DEPTH_BITS] != rd_ptr[DEPTH_BITS]) &&
                   (wr_ptr[DEPTH_BITS-1:0] == rd_ptr[DEPTH_BITS-1:0]);

  assign do_wr_c   = wr_en && !full_c;
  assign do_rd_c   = rd_en && !empty_c;
  assign rd_data_c = mem[rd_ptr[DEPTH_BITS-1:0]];

  // Pointer update
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr_c) wr_ptr <= wr_ptr + (DEPTH_BITS+1)'(1);
      if (do_rd_c) rd_ptr <= rd_ptr + (DEPTH_BITS+1)'(1);
    end
  end

  // Storage, contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_wr_c) mem[wr_ptr[DEPTH_BITS-1:0]] <= wr_data;
  end

endmodule

// File: rtl/action_dispatch.sv
// Egress dispatch stage: buffers {data, action, state} in a FWFT FIFO,
// decodes the forward byte at the head and emits unicast, controller or
// broadcast beats through a registered valid/ready output; unknown codes
// are dropped. Saturating counters track accepted beats, decode drops and
// FIFO overflow losses.
//   clk, reset : clock, sync active-high reset
//   bus        : packet input and valid/ready output (slave modport)
//   fwd_cnt    : beats accepted downstream
//   drop_cnt   : packets discarded by decode
//   ovf_cnt    : packets lost to a full FIFO
module action_dispatch
  import action_dispatch_pkg::*;
#(
  parameter int unsigned DATA_W          = 512,
  parameter int unsigned NUM_PORTS       = 4,
  parameter int unsigned CTRL_PORT       = NUM_PORTS - 1,
  parameter int unsigned FIFO_DEPTH_BITS = 4
) (
  input  logic             clk,
  input  logic             reset,
  action_dispatch_if.slave bus,
  output logic [CNT_W-1:0] fwd_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] ovf_cnt
);
  localparam int unsigned META_W  = $bits(pkt_meta_t);
  localparam int unsigned ENTRY_W = DATA_W + META_W;
  localparam logic [PORT_W-1:0] CTRL_IDX    = PORT_W'(CTRL_PORT);
  localparam logic [PORT_W-1:0] LAST_IDX    = PORT_W'(NUM_PORTS - 1);
  localparam logic [PORT_W-1:0] NUM_PORTS_P = PORT_W'(NUM_PORTS);
  localparam bit                MULTI_PORT  = (NUM_PORTS > 1);

  logic               fifo_full_c;
  logic               fifo_empty_c;
  logic [ENTRY_W-1:0] head_c;
  logic [DATA_W-1:0]  head_data_c;
  pkt_meta_t          head_meta_c;
  logic [7:0]         fwd_c;
  logic               is_ctrl_c;
  logic               is_uni_c;
  logic               is_bcast_c;
  logic               out_free_c;
  logic               unused_action_c;

  fsm_e               fsm_q;
  fsm_e               fsm_nxt_c;
  logic [PORT_W-1:0]  bc_idx;
  logic [PORT_W-1:0]  bc_idx_nxt_c;
  logic [PORT_W-1:0]  load_port_c;
  logic               load_c;
  logic               pop_c;
  logic               drop_c;

  logic               vld_q;
  logic [DATA_W-1:0]  data_q;
  logic [PORT_W-1:0]  port_q;
  logic [STATE_W-1:0] state_q;

  dispatch_fifo #(
    .WIDTH      (ENTRY_W),
    .DEPTH_BITS (FIFO_DEPTH_BITS)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (bus.pkt_vld_in),
    .wr_data   ({bus.pkt_data_in, bus.action_in, bus.state_in}),
    .rd_en     (pop_c),
    .rd_data_c (head_c),
    .full_c    (fifo_full_c),
    .empty_c   (fifo_empty_c)
  );

  // Head entry split and forward-byte decode
  assign head_data_c = head_c[ENTRY_W-1 -: DATA_W];
  assign head_meta_c = pkt_meta_t'(head_c[META_W-1:0]);
  assign fwd_c       = head_meta_c.action[FWD_HI:FWD_LO];
  assign is_ctrl_c   = (fwd_c == ACT_CTRL);
  assign is_bcast_c  = (fwd_c == ACT_BCAST);
  assign is_uni_c    = !is_ctrl_c && (fwd_c <= NUM_PORTS_P);

  // State-update flag is informational only at this stage
  assign unused_action_c = ^head_meta_c.action[FWD_LO-1:0];

  // Output register can take a new beat when empty or being accepted
  assign out_free_c = !vld_q || bus.pkt_rdy_in;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) fsm_q <= IDLE;
    else       fsm_q <= fsm_nxt_c;
  end

  // FSM next state
  always_comb begin
    fsm_nxt_c = fsm_q;
    case (fsm_q)
      IDLE: begin
        if (!fifo_empty_c && out_free_c && is_bcast_c && MULTI_PORT)
          fsm_nxt_c = BCAST;
      end
      BCAST: begin
        if (out_free_c && (bc_idx == LAST_IDX)) fsm_nxt_c = IDLE;
      end
      default: fsm_nxt_c = IDLE;
    endcase
  end

  // FSM outputs: output-register load, FIFO pop, drop strobe, broadcast index
  always_comb begin
    load_c       = 1'b0;
    load_port_c  = '0;
    pop_c        = 1'b0;
    drop_c       = 1'b0;
    bc_idx_nxt_c = bc_idx;
    case (fsm_q)
      IDLE: begin
        if (!fifo_empty_c) begin
          if (is_ctrl_c || is_uni_c) begin
            if (out_free_c) begin
              load_c      = 1'b1;
              load_port_c = is_ctrl_c ? CTRL_IDX : (fwd_c - 8'd1);
              pop_c       = 1'b1;
            end
          end else if (is_bcast_c) begin
            if (out_free_c) begin
              load_c      = 1'b1;
              load_port_c = '0;
              if (MULTI_PORT) bc_idx_nxt_c = PORT_W'(1);
              else            pop_c        = 1'b1;
            end
          end else begin
            // Unknown code: discard without touching the output register
            pop_c  = 1'b1;
            drop_c = 1'b1;
          end
        end
      end
      BCAST: begin
        if (out_free_c) begin
          load_c      = 1'b1;
          load_port_c = bc_idx;
          if (bc_idx == LAST_IDX) begin
            pop_c        = 1'b1;
            bc_idx_nxt_c = '0;
          end else begin
            bc_idx_nxt_c = bc_idx + PORT_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // Broadcast port index
  always_ff @(posedge clk) begin
    if (reset) bc_idx <= '0;
    else       bc_idx <= bc_idx_nxt_c;
  end

  // Output register: reloads on the accepting edge, holds while stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q   <= 1'b0;
      data_q  <= '0;
      port_q  <= '0;
      state_q <= '0;
    end else if (load_c) begin
      vld_q   <= 1'b1;
      data_q  <= head_data_c;
      port_q  <= load_port_c;
      state_q <= head_meta_c.state;
    end else if (bus.pkt_rdy_in) begin
      vld_q   <= 1'b0;
    end
  end

  assign bus.pkt_vld_out   = vld_q;
  assign bus.pkt_data_out  = data_q;
  assign bus.pkt_port_out  = port_q;
  assign bus.pkt_state_out = state_q;

  // Saturating statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_cnt  <= '0;
      drop_cnt <= '0;
      ovf_cnt  <= '0;
    end else begin
      if (vld_q && bus.pkt_rdy_in)           fwd_cnt  <= sat_inc(fwd_cnt);
      if (drop_c)                            drop_cnt <= sat_inc(drop_cnt);
      if (bus.pkt_vld_in && fifo_full_c)     ovf_cnt  <= sat_inc(ovf_cnt);
    end
  end

endmodule

// File: tb/tb_action_dispatch.sv
// Self-checking bench for action_dispatch: directed scenarios plus random
// bursts, checked against a packet-level reference model (expected beat
// queue and expected counter totals).
module tb_action_dispatch;

  localparam int unsigned DW  = 512;
  localparam int unsigned NP  = 4;
  localparam int unsigned CP  = NP - 1;
  localparam int unsigned FDB = 4;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] fwd_cnt;
  logic [31:0] drop_cnt;
  logic [31:0] ovf_cnt;

  action_dispatch_if #(.DATA_W(DW)) bus ();

  action_dispatch #(
    .DATA_W          (DW),
    .NUM_PORTS       (NP),
    .CTRL_PORT       (CP),
    .FIFO_DEPTH_BITS (FDB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .fwd_cnt  (fwd_cnt),
    .drop_cnt (drop_cnt),
    .ovf_cnt  (ovf_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [7:0]    port;
    logic [7:0]    state;
  } beat_t;

  beat_t       exp_q[$];
  int          vectors     = 0;
  int          miscompares = 0;
  int unsigned exp_fwd     = 0;
  int unsigned exp_drop    = 0;
  int unsigned exp_ovf     = 0;

  bit          stalled_prev = 1'b0;
  logic [DW-1:0] hold_data;
  logic [7:0]  hold_port;
  logic [7:0]  hold_state;

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] v;
    for (int i = 0; i < int'(DW / 32); i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // Mix of controller, unicast, broadcast, boundary drop and other drops
  function automatic logic [7:0] rand_fwd();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r <= 1)      return 8'h00;
    else if (r <= 5) return 8'($urandom_range(1, NP));
    else if (r <= 7) return 8'hFF;
    else if (r == 8) return 8'(NP + 1);
    else             return 8'($urandom_range(NP + 2, 254));
  endfunction

  // Reference model: what one accepted packet turns into downstream
  function automatic void model_pkt(input logic [7:0] f, input logic [DW-1:0] d,
                                    input logic [7:0] s);
    beat_t b;
    b.data  = d;
    b.state = s;
    if (f == 8'h00) begin
      b.port = 8'(CP);
      exp_q.push_back(b);
      exp_fwd++;
    end else if (f <= 8'(NP)) begin
      b.port = f - 8'd1;
      exp_q.push_back(b);
      exp_fwd++;
    end else if (f == 8'hFF) begin
      for (int p = 0; p < int'(NP); p++) begin
        b.port = 8'(p);
        exp_q.push_back(b);
        exp_fwd++;
      end
    end else begin
      exp_drop++;
    end
  endfunction

  // Negedge sampling: beat ordering/content and hold-while-stalled
  task automatic sample();
    beat_t b;
    @(negedge clk);
    if (reset) begin
      stalled_prev = 1'b0;
    end else begin
      if (stalled_prev) begin
        vectors++;
        if (bus.pkt_vld_out !== 1'b1 || bus.pkt_data_out !== hold_data ||
            bus.pkt_port_out !== hold_port || bus.pkt_state_out !== hold_state) begin
          miscompares++;
          $display("FAIL hold_stable: vld=%0b port=%0d state=%02h, required vld=1 port=%0d state=%02h",
                   bus.pkt_vld_out, bus.pkt_port_out, bus.pkt_state_out, hold_port, hold_state);
        end
      end
      if (bus.pkt_vld_out === 1'b1 && bus.pkt_rdy_in === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_beat: port=%0d state=%02h, required no beat",
                   bus.pkt_port_out, bus.pkt_state_out);
        end else begin
          b = exp_q.pop_front();
          if (bus.pkt_port_out !== b.port || bus.pkt_state_out !== b.state ||
              bus.pkt_data_out !== b.data) begin
            miscompares++;
            $display("FAIL beat: port=%0d state=%02h data=%016h, required port=%0d state=%02h data=%016h",
                     bus.pkt_port_out, bus.pkt_state_out, bus.pkt_data_out[63:0],
                     b.port, b.state, b.data[63:0]);
          end
        end
      end
      stalled_prev = (bus.pkt_vld_out === 1'b1) && (bus.pkt_rdy_in === 1'b0);
      hold_data    = bus.pkt_data_out;
      hold_port    = bus.pkt_port_out;
      hold_state   = bus.pkt_state_out;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    exp_q.delete();
    exp_fwd      = 0;
    exp_drop     = 0;
    exp_ovf      = 0;
    stalled_prev = 1'b0;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    bus.pkt_vld_in = 1'b0;
    sample();
    advance();
    sample();
    advance();
    reset = 1'b0;
    clear_model();
  endtask

  // One input packet for one cycle; accept=0 means the model expects it lost
  task automatic send(input logic [7:0] f, input logic [7:0] s,
                      input logic [DW-1:0] d, input bit accept);
    bus.pkt_vld_in  = 1'b1;
    bus.action_in   = {f, 8'($urandom)};
    bus.state_in    = s;
    bus.pkt_data_in = d;
    if (accept) model_pkt(f, d, s);
    else        exp_ovf++;
    sample();
    advance();
    bus.pkt_vld_in = 1'b0;
  endtask

  // Run until the model has nothing pending, then compare the counters
  task automatic drain(input bit rand_rdy);
    int idle = 0;
    int cyc  = 0;
    while (idle < 3 && cyc < 400) begin
      if (rand_rdy) bus.pkt_rdy_in = ($urandom_range(0, 3) != 0);
      sample();
      if (exp_q.size() == 0 && bus.pkt_vld_out !== 1'b1) idle++;
      else idle = 0;
      advance();
      cyc++;
    end
    vectors++;
    if (idle < 3) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d beats still expected, required 0", exp_q.size());
    end
    sample();
    vectors++;
    if (fwd_cnt !== exp_fwd) begin
      miscompares++;
      $display("FAIL fwd_cnt: got %0d, required %0d", fwd_cnt, exp_fwd);
    end
    vectors++;
    if (drop_cnt !== exp_drop) begin
      miscompares++;
      $display("FAIL drop_cnt: got %0d, required %0d", drop_cnt, exp_drop);
    end
    vectors++;
    if (ovf_cnt !== exp_ovf) begin
      miscompares++;
      $display("FAIL ovf_cnt: got %0d, required %0d", ovf_cnt, exp_ovf);
    end
    advance();
  endtask

  task automatic check_all_zero(input string tag);
    vectors++;
    if (bus.pkt_vld_out !== 1'b0 || bus.pkt_data_out !== '0 ||
        bus.pkt_port_out !== 8'd0 || bus.pkt_state_out !== 8'd0) begin
      miscompares++;
      $display("FAIL %s_outputs: vld=%0b port=%0d state=%02h data=%016h, required all 0",
               tag, bus.pkt_vld_out, bus.pkt_port_out, bus.pkt_state_out, bus.pkt_data_out[63:0]);
    end
    vectors++;
    if (fwd_cnt !== 32'd0 || drop_cnt !== 32'd0 || ovf_cnt !== 32'd0) begin
      miscompares++;
      $display("FAIL %s_counters: fwd=%0d drop=%0d ovf=%0d, required 0 0 0",
               tag, fwd_cnt, drop_cnt, ovf_cnt);
    end
  endtask

  // Unicast with a latency check: valid appears two cycles after input
  task automatic unicast_latency(input logic [7:0] f, input string tag);
    logic [DW-1:0] d;
    logic [7:0]    s;
    d = rand_data();
    s = 8'($urandom);
    bus.pkt_rdy_in  = 1'b1;
    bus.pkt_vld_in  = 1'b1;
    bus.action_in   = {f, 8'h01};
    bus.state_in    = s;
    bus.pkt_data_in = d;
    model_pkt(f, d, s);
    sample();
    advance();
    bus.pkt_vld_in = 1'b0;
    sample();
    vectors++;
    if (bus.pkt_vld_out !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_early: vld=%0b at N+1, required 0", tag, bus.pkt_vld_out);
    end
    advance();
    sample();
    vectors++;
    if (bus.pkt_vld_out !== 1'b1 || bus.pkt_port_out !== f - 8'd1 ||
        bus.pkt_state_out !== s || bus.pkt_data_out !== d) begin
      miscompares++;
      $display("FAIL %s_n2: vld=%0b port=%0d state=%02h, required vld=1 port=%0d state=%02h",
               tag, bus.pkt_vld_out, bus.pkt_port_out, bus.pkt_state_out, f - 8'd1, s);
    end
    advance();
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    bus.pkt_vld_in = 1'b0;
    bus.pkt_rdy_in = 1'b0;
    sample();
    advance();
    sample();
    check_all_zero("reset");
    advance();
    reset = 1'b0;
    clear_model();
  endtask

  task automatic test_unicast();
    logic [DW-1:0] d;
    do_reset();
    d = rand_data();
    bus.pkt_rdy_in  = 1'b1;
    bus.pkt_vld_in  = 1'b1;
    bus.action_in   = 16'h0201;
    bus.state_in    = 8'h01;
    bus.pkt_data_in = d;
    model_pkt(8'h02, d, 8'h01);
    sample();
    advance();
    bus.pkt_vld_in = 1'b0;
    sample();
    vectors++;
    if (bus.pkt_vld_out !== 1'b0) begin
      miscompares++;
      $display("FAIL unicast_early: vld=%0b, required 0", bus.pkt_vld_out);
    end
    advance();
    sample();
    vectors++;
    if (bus.pkt_vld_out !== 1'b1 || bus.pkt_port_out !== 8'd1 ||
        bus.pkt_state_out !== 8'h01 || bus.pkt_data_out !== d) begin
      miscompares++;
      $display("FAIL unicast_beat: vld=%0b port=%0d state=%02h, required vld=1 port=1 state=01",
               bus.pkt_vld_out, bus.pkt_port_out, bus.pkt_state_out);
    end
    advance();
    sample();
    vectors++;
    if (fwd_cnt !== 32'd1) begin
      miscompares++;
      $display("FAIL unicast_fwd_cnt: got %0d, required 1", fwd_cnt);
    end
    advance();
    drain(1'b0);
  endtask

  task automatic test_bcast_stall();
    do_reset();
    bus.pkt_rdy_in = 1'b1;
    send(8'hFF, 8'h5A, rand_data(), 1'b1);
    bus.pkt_rdy_in = 1'b0;
    send(8'h01, 8'hA5, rand_data(), 1'b1);
    // Port 0 is now valid; stall it for three cycles
    for (int i = 0; i < 3; i++) begin
      sample();
      advance();
    end
    bus.pkt_rdy_in = 1'b1;
    drain(1'b0);
  endtask

  task automatic test_ctrl_drop();
    do_reset();
    bus.pkt_rdy_in = 1'b1;
    send(8'h00, 8'h11, rand_data(), 1'b1);
    send(8'h09, 8'h22, rand_data(), 1'b1);
    send(8'(NP + 1), 8'h33, rand_data(), 1'b1);
    send(8'(NP), 8'h44, rand_data(), 1'b1);
    drain(1'b0);
  endtask

  task automatic test_overflow();
    do_reset();
    bus.pkt_rdy_in = 1'b0;
    for (int i = 0; i < 20; i++)
      send(8'($urandom_range(0, NP)), 8'(i), rand_data(), i < 17);
    sample();
    vectors++;
    if (ovf_cnt !== 32'd3 || bus.pkt_vld_out !== 1'b1 || fwd_cnt !== 32'd0) begin
      miscompares++;
      $display("FAIL overflow_stalled: ovf=%0d vld=%0b fwd=%0d, required ovf=3 vld=1 fwd=0",
               ovf_cnt, bus.pkt_vld_out, fwd_cnt);
    end
    advance();
    bus.pkt_rdy_in = 1'b1;
    drain(1'b0);
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d;
    logic [7:0]    f;
    logic [7:0]    s;
    bit            want;
    do_reset();
    bus.pkt_rdy_in = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (i < 8) begin
        d = rand_data();
        f = 8'($urandom_range(1, NP));
        s = 8'($urandom);
        bus.pkt_vld_in  = 1'b1;
        bus.action_in   = {f, 8'h00};
        bus.state_in    = s;
        bus.pkt_data_in = d;
        model_pkt(f, d, s);
      end else begin
        bus.pkt_vld_in = 1'b0;
      end
      sample();
      want = (i >= 2) && (i <= 9);
      vectors++;
      if (bus.pkt_vld_out !== want) begin
        miscompares++;
        $display("FAIL back_to_back_cycle%0d: vld=%0b, required %0b", i, bus.pkt_vld_out, want);
      end
      advance();
    end
    bus.pkt_vld_in = 1'b0;
    drain(1'b0);
  endtask

  task automatic test_reset_bcast();
    bit found = 1'b0;
    do_reset();
    bus.pkt_rdy_in = 1'b1;
    send(8'hFF, 8'h77, rand_data(), 1'b1);
    for (int k = 0; k < 10 && !found; k++) begin
      sample();
      if (bus.pkt_vld_out === 1'b1 && bus.pkt_port_out === 8'd1) found = 1'b1;
      advance();
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL reset_bcast_port1: port 1 beat not seen, required within 10 cycles");
    end
    reset = 1'b1;
    clear_model();
    advance();
    sample();
    check_all_zero("reset_bcast");
    advance();
    reset = 1'b0;
    unicast_latency(8'($urandom_range(1, NP)), "post_reset");
    drain(1'b0);
  endtask

  task automatic test_random();
    do_reset();
    for (int burst = 0; burst < 6; burst++) begin
      for (int i = 0; i < 10; i++) begin
        bus.pkt_rdy_in = ($urandom_range(0, 1) != 0);
        if ($urandom_range(0, 3) != 0) begin
          send(rand_fwd(), 8'($urandom), rand_data(), 1'b1);
        end else begin
          sample();
          advance();
        end
      end
      drain(1'b1);
    end
    bus.pkt_rdy_in = 1'b1;
  endtask

  initial begin
    bus.pkt_vld_in  = 1'b0;
    bus.pkt_data_in = '0;
    bus.action_in   = '0;
    bus.state_in    = '0;
    bus.pkt_rdy_in  = 1'b0;
    advance();
    test_reset();
    test_unicast();
    test_bcast_stall();
    test_ctrl_drop();
    test_overflow();
    test_back_to_back();
    test_reset_bcast();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
